// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the RV32 memory-access stage:
//   - load/store funct3 encodings
//   - mem_stage FSM state encoding
//   - latched request record carried from EX acceptance to completion
// -----------------------------------------------------------------------------
package mem_pkg;

  localparam int MEM_XLEN = 32;
  localparam int MEM_RD_W = 5;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // One EX result as captured at accept time.
  typedef struct packed {
    logic [MEM_XLEN-1:0] addr;
    logic [MEM_XLEN-1:0] sdata;
    logic [2:0]          funct3;
    logic [MEM_RD_W-1:0] rd;
    logic                load;
    logic                store;
    logic                reg_write;
  } req_t;

endpackage

// File: rtl/mem_stage_store_align.sv
// -----------------------------------------------------------------------------
// store_align
// Combinational byte-enable and lane-replicated write data for stores.
// Ports:
//   size_i     : funct3[1:0] of the store (B/H/W)
//   addr_lo_i  : effective address bits [1:0]
//   data_i     : rs2 value
//   mask_o     : byte enables (bit n = byte lane n)
//   wdata_o    : store data replicated across all lanes of its size
// Halfword stores use addr[1] only; word stores ignore addr[1:0].
// -----------------------------------------------------------------------------
module store_align
  import mem_pkg::*;
(
  input  logic [1:0]          size_i,
  input  logic [1:0]          addr_lo_i,
  input  logic [MEM_XLEN-1:0] data_i,
  output logic [3:0]          mask_o,
  output logic [MEM_XLEN-1:0] wdata_o
);

  always_comb begin
    mask_o  = 4'b1111;
    wdata_o = data_i;
    case (size_i)
      F3_B[1:0]: begin
        mask_o  = 4'b0001 << addr_lo_i;
        wdata_o = {4{data_i[7:0]}};
      end
      F3_H[1:0]: begin
        mask_o  = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{data_i[15:0]}};
      end
      default: begin
        mask_o  = 4'b1111;
        wdata_o = data_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// RV32 memory-access stage between execute and writeback. Accepts one EX
// result per i_valid/!o_stall handshake, issues at most one data-memory
// access (ready/rvalid handshake), and registers the MEM/WB boundary.
// Writeback performs the final lane extraction and sign/zero extension.
//
// Optional build macro: MEM_MISALIGN_TRAP_EN
//   Defined  : misaligned LH/LHU/SH/LW/SW skip the memory, complete next
//              cycle with o_reg_write=0 and o_misaligned=1.
//   Undefined: no o_misaligned port; halfword ignores addr[0], word ignores
//              addr[1:0].
//
// Ports:
//   i_clk, i_rst (async, active-low)
//   EX side : i_valid, i_ex_data, i_store_data, i_mem_read, i_mem_write,
//             i_funct3, i_rd_addr, i_reg_write, o_stall
//   DMEM    : o_dmem_req, o_dmem_addr, o_dmem_wen, o_dmem_mask, o_dmem_wdata,
//             i_dmem_ready, i_dmem_rvalid, i_dmem_rdata
//   WB side : o_wb_valid (1-cycle pulse), o_ex_data_out, o_dmem_rdata,
//             o_mem_read, o_is_word, o_is_h_or_b, o_is_unsigned_ld,
//             o_rd_addr, o_reg_write [, o_misaligned]
// -----------------------------------------------------------------------------
module mem_stage
  import mem_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic [XLEN-1:0]    i_ex_data,
  input  logic [XLEN-1:0]    i_store_data,
  input  logic               i_mem_read,
  input  logic               i_mem_write,
  input  logic [2:0]         i_funct3,
  input  logic [RADDR_W-1:0] i_rd_addr,
  input  logic               i_reg_write,
  output logic               o_stall,
  output logic               o_dmem_req,
  output logic [XLEN-1:0]    o_dmem_addr,
  output logic               o_dmem_wen,
  output logic [3:0]         o_dmem_mask,
  output logic [XLEN-1:0]    o_dmem_wdata,
  input  logic               i_dmem_ready,
  input  logic               i_dmem_rvalid,
  input  logic [XLEN-1:0]    i_dmem_rdata,
  output logic               o_wb_valid,
  output logic [XLEN-1:0]    o_ex_data_out,
  output logic [XLEN-1:0]    o_dmem_rdata,
  output logic               o_mem_read,
  output logic               o_is_word,
  output logic               o_is_h_or_b,
  output logic               o_is_unsigned_ld,
  output logic [RADDR_W-1:0] o_rd_addr,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic               o_misaligned,
`endif
  output logic               o_reg_write
);

  state_e state_q, state_d;
  req_t   req_q, req_d;
  req_t   in_req;
  req_t   cpl_src;
  logic   cpl_en;
  logic [XLEN-1:0] cpl_rdata;
  logic   in_misal;

  logic               wb_valid_q, wb_valid_d;
  logic [XLEN-1:0]    ex_out_q, ex_out_d;
  logic [XLEN-1:0]    rdata_q, rdata_d;
  logic               mread_q, mread_d;
  logic               is_word_q, is_word_d;
  logic               is_hb_q, is_hb_d;
  logic               is_uns_q, is_uns_d;
  logic [RADDR_W-1:0] rd_q, rd_d;
  logic               rw_q, rw_d;
`ifdef MEM_MISALIGN_TRAP_EN
  logic               cpl_mis;
  logic               mis_q, mis_d;
`endif

  logic [3:0]      st_mask;
  logic [XLEN-1:0] st_wdata;

  // Store+load together is a store.
  always_comb begin
    in_req           = '0;
    in_req.addr      = i_ex_data;
    in_req.sdata     = i_store_data;
    in_req.funct3    = i_funct3;
    in_req.rd        = i_rd_addr;
    in_req.load      = i_mem_read & ~i_mem_write;
    in_req.store     = i_mem_write;
    in_req.reg_write = i_reg_write;
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_comb begin
    in_misal = 1'b0;
    if (i_mem_read || i_mem_write) begin
      if (i_funct3[1:0] == F3_H[1:0]) in_misal = i_ex_data[0];
      if (i_funct3[1:0] == F3_W[1:0]) in_misal = |i_ex_data[1:0];
    end
  end
`else
  assign in_misal = 1'b0;
`endif

  // Next state and request latch. Non-memory (and trapped) ops complete
  // straight from IDLE using the incoming fields.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    cpl_en    = 1'b0;
    cpl_src   = req_q;
    cpl_rdata = '0;
`ifdef MEM_MISALIGN_TRAP_EN
    cpl_mis   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          req_d = in_req;
          if ((in_req.load || in_req.store) && !in_misal) begin
            state_d = ST_REQ;
          end else begin
            cpl_en  = 1'b1;
            cpl_src = in_req;
`ifdef MEM_MISALIGN_TRAP_EN
            cpl_mis = in_misal;
`endif
          end
        end
      end
      ST_REQ: begin
        if (i_dmem_ready) begin
          if (req_q.store) begin
            cpl_en  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (i_dmem_rvalid) begin
          cpl_en    = 1'b1;
          cpl_rdata = i_dmem_rdata;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // MEM/WB boundary: fields hold until the next completion.
  always_comb begin
    wb_valid_d = cpl_en;
    ex_out_d   = ex_out_q;
    rdata_d    = rdata_q;
    mread_d    = mread_q;
    is_word_d  = is_word_q;
    is_hb_d    = is_hb_q;
    is_uns_d   = is_uns_q;
    rd_d       = rd_q;
    rw_d       = rw_q;
`ifdef MEM_MISALIGN_TRAP_EN
    mis_d      = mis_q;
`endif
    if (cpl_en) begin
      ex_out_d  = cpl_src.addr;
      rdata_d   = cpl_rdata;
      mread_d   = cpl_src.load;
      is_word_d = (cpl_src.funct3[1:0] == F3_W[1:0]);
      is_hb_d   = (cpl_src.funct3[1:0] == F3_H[1:0]);
      is_uns_d  = cpl_src.funct3[2];
      rd_d      = cpl_src.rd;
`ifdef MEM_MISALIGN_TRAP_EN
      rw_d      = cpl_src.reg_write & ~cpl_mis;
      mis_d     = cpl_mis;
`else
      rw_d      = cpl_src.reg_write;
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      wb_valid_q <= 1'b0;
      ex_out_q   <= '0;
      rdata_q    <= '0;
      mread_q    <= 1'b0;
      is_word_q  <= 1'b0;
      is_hb_q    <= 1'b0;
      is_uns_q   <= 1'b0;
      rd_q       <= '0;
      rw_q       <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      wb_valid_q <= wb_valid_d;
      ex_out_q   <= ex_out_d;
      rdata_q    <= rdata_d;
      mread_q    <= mread_d;
      is_word_q  <= is_word_d;
      is_hb_q    <= is_hb_d;
      is_uns_q   <= is_uns_d;
      rd_q       <= rd_d;
      rw_q       <= rw_d;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q      <= mis_d;
`endif
    end
  end

  store_align u_store_align (
    .size_i    (req_q.funct3[1:0]),
    .addr_lo_i (req_q.addr[1:0]),
    .data_i    (req_q.sdata),
    .mask_o    (st_mask),
    .wdata_o   (st_wdata)
  );

  // DMEM port is driven from the latched request only while in REQ, so it
  // is stable until ready and quiet (all zero) otherwise.
  assign o_stall      = (state_q != ST_IDLE);
  assign o_dmem_req   = (state_q == ST_REQ);
  assign o_dmem_addr  = o_dmem_req ? {req_q.addr[XLEN-1:2], 2'b00} : '0;
  assign o_dmem_wen   = o_dmem_req & req_q.store;
  assign o_dmem_mask  = o_dmem_req ? (req_q.store ? st_mask : 4'b1111) : 4'b0000;
  assign o_dmem_wdata = o_dmem_wen ? st_wdata : '0;

  assign o_wb_valid       = wb_valid_q;
  assign o_ex_data_out    = ex_out_q;
  assign o_dmem_rdata     = rdata_q;
  assign o_mem_read       = mread_q;
  assign o_is_word        = is_word_q;
  assign o_is_h_or_b      = is_hb_q;
  assign o_is_unsigned_ld = is_uns_q;
  assign o_rd_addr        = rd_q;
  assign o_reg_write      = rw_q;
`ifdef MEM_MISALIGN_TRAP_EN
  assign o_misaligned     = mis_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Self-checking bench for mem_stage: a table of directed vectors, hand-written
// back-to-back / reset / misalignment sequences, and random operations checked
// against an arithmetic reference model. Honours MEM_MISALIGN_TRAP_EN.
// -----------------------------------------------------------------------------
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [31:0] ex_data, store_data;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [4:0]  rd_addr;
  logic        reg_write;
  logic        stall, dreq, dwen, dready, drvalid;
  logic [31:0] daddr, dwdata, drdata_in;
  logic [3:0]  dmask;
  logic        wb_valid, o_mread, is_word, is_hb, is_uns, o_rw;
  logic [31:0] ex_out, rdata_out;
  logic [4:0]  o_rd;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misal;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .i_clk            (clk),
    .i_rst            (rst_n),
    .i_valid          (valid),
    .i_ex_data        (ex_data),
    .i_store_data     (store_data),
    .i_mem_read       (mem_read),
    .i_mem_write      (mem_write),
    .i_funct3         (funct3),
    .i_rd_addr        (rd_addr),
    .i_reg_write      (reg_write),
    .o_stall          (stall),
    .o_dmem_req       (dreq),
    .o_dmem_addr      (daddr),
    .o_dmem_wen       (dwen),
    .o_dmem_mask      (dmask),
    .o_dmem_wdata     (dwdata),
    .i_dmem_ready     (dready),
    .i_dmem_rvalid    (drvalid),
    .i_dmem_rdata     (drdata_in),
    .o_wb_valid       (wb_valid),
    .o_ex_data_out    (ex_out),
    .o_dmem_rdata     (rdata_out),
    .o_mem_read       (o_mread),
    .o_is_word        (is_word),
    .o_is_h_or_b      (is_hb),
    .o_is_unsigned_ld (is_uns),
    .o_rd_addr        (o_rd),
`ifdef MEM_MISALIGN_TRAP_EN
    .o_misaligned     (misal),
`endif
    .o_reg_write      (o_rw)
  );

  typedef struct {
    logic [31:0] ex;
    logic [31:0] sd;
    logic        mr;
    logic        mw;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        rw;
    int          rdy_dly;
    int          rv_dly;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [3:0]  e_mask;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic        e_misal;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(input logic [31:0] ex, input logic [31:0] sd,
                               input logic mr, input logic mw, input logic [2:0] f3,
                               input logic [4:0] rd, input logic rw,
                               input int rdy, input int rv, input logic [31:0] rdata,
                               input logic [31:0] e_addr, input logic [3:0] e_mask,
                               input logic [31:0] e_wdata, input logic [31:0] e_rdata);
    vec_t v;
    v.ex = ex; v.sd = sd; v.mr = mr; v.mw = mw; v.f3 = f3; v.rd = rd; v.rw = rw;
    v.rdy_dly = rdy; v.rv_dly = rv; v.rdata = rdata;
    v.e_addr = e_addr; v.e_mask = e_mask; v.e_wdata = e_wdata; v.e_rdata = e_rdata;
    v.e_misal = 1'b0;
    return v;
  endfunction

  // Reference model: expected memory-port and writeback values from the
  // architectural rules, using plain arithmetic.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int   a    = int'(v.ex % 4);
    int   size = int'(v.f3 % 4);
    bit   st   = v.mw;
    bit   ld   = v.mr && !v.mw;
    r.e_misal = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    if ((st || ld) && ((size == 1 && (a % 2) == 1) || (size == 2 && a != 0))) r.e_misal = 1'b1;
`endif
    r.e_addr = v.ex - 32'(a);
    if (ld) r.e_mask = 4'd15;
    else if (size == 0) r.e_mask = 4'(1 << a);
    else if (size == 1) r.e_mask = (a >= 2) ? 4'd12 : 4'd3;
    else r.e_mask = 4'd15;
    if (size == 0) r.e_wdata = (v.sd % 256) * 32'h0101_0101;
    else if (size == 1) r.e_wdata = (v.sd % 65536) * 32'h0001_0001;
    else r.e_wdata = v.sd;
    r.e_rdata = (ld && !r.e_misal) ? v.rdata : 32'd0;
    return r;
  endfunction

  // Runs one operation starting just after a rising edge with the DUT able
  // to accept; returns in the cycle o_wb_valid is expected high.
  task automatic run_op(input vec_t v, input string tag);
    bit st   = v.mw;
    bit ld   = v.mr && !v.mw;
    bit mem  = (st || ld) && !v.e_misal;
    chk({tag, ".stall_pre"}, 32'(stall), 32'd0);
    valid = 1'b1; ex_data = v.ex; store_data = v.sd; mem_read = v.mr;
    mem_write = v.mw; funct3 = v.f3; rd_addr = v.rd; reg_write = v.rw;
    @(posedge clk); #1;
    valid = 1'b0; ex_data = $urandom; store_data = $urandom;
    mem_read = 1'($urandom); mem_write = 1'($urandom); funct3 = 3'($urandom);
    rd_addr = 5'($urandom); reg_write = 1'($urandom);
    if (mem) begin
      chk({tag, ".req"},   32'(dreq),  32'd1);
      chk({tag, ".stall"}, 32'(stall), 32'd1);
      chk({tag, ".addr"},  daddr,      v.e_addr);
      chk({tag, ".wen"},   32'(dwen),  32'(st));
      chk({tag, ".mask"},  32'(dmask), 32'(v.e_mask));
      if (st) chk({tag, ".wdata"}, dwdata, v.e_wdata);
      repeat (v.rdy_dly) begin @(posedge clk); #1; end
      chk({tag, ".addr_hold"}, daddr, v.e_addr);
      chk({tag, ".req_hold"}, 32'(dreq), 32'd1);
      dready = 1'b1;
      @(posedge clk); #1;
      dready = 1'b0;
      if (ld) begin
        chk({tag, ".req_drop"}, 32'(dreq), 32'd0);
        chk({tag, ".stall_resp"}, 32'(stall), 32'd1);
        repeat (v.rv_dly) begin @(posedge clk); #1; end
        drvalid = 1'b1; drdata_in = v.rdata;
        @(posedge clk); #1;
        drvalid = 1'b0; drdata_in = $urandom;
      end
    end else begin
      chk({tag, ".noreq"}, 32'(dreq), 32'd0);
    end
    chk({tag, ".wb_valid"}, 32'(wb_valid),  32'd1);
    chk({tag, ".ex_out"},   ex_out,         v.ex);
    chk({tag, ".rdata"},    rdata_out,      v.e_rdata);
    chk({tag, ".mem_read"}, 32'(o_mread),   32'(ld));
    chk({tag, ".is_word"},  32'(is_word),   32'(v.f3 % 4 == 2));
    chk({tag, ".is_hb"},    32'(is_hb),     32'(v.f3 % 4 == 1));
    chk({tag, ".is_uns"},   32'(is_uns),    32'(v.f3 / 4));
    chk({tag, ".rd"},       32'(o_rd),      32'(v.rd));
    chk({tag, ".reg_write"},32'(o_rw),      32'(v.rw && !v.e_misal));
`ifdef MEM_MISALIGN_TRAP_EN
    chk({tag, ".misal"},    32'(misal),     32'(v.e_misal));
`endif
    chk({tag, ".stall_done"}, 32'(stall), 32'd0);
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk); #1;
    chk({tag, ".wb_pulse_end"}, 32'(wb_valid), 32'd0);
  endtask

  vec_t tbl[$];
  vec_t v;
  logic [2:0] ld_f3s[5];

  initial begin
    ld_f3s[0] = 3'b000; ld_f3s[1] = 3'b001; ld_f3s[2] = 3'b010;
    ld_f3s[3] = 3'b100; ld_f3s[4] = 3'b101;
    //          ex            sd            mr mw f3      rd  rw rdy rv rdata         addr          mask     wdata         rdata
    tbl.push_back(mkv(32'h0000_1234, 32'h0,        0, 0, 3'b000, 5,  1, 0, 0, 32'h0,        32'h0,        4'h0,    32'h0,        32'h0));
    tbl.push_back(mkv(32'h0000_0103, 32'h0000_00AB,0, 1, 3'b000, 0,  0, 1, 0, 32'h0,        32'h0000_0100,4'b1000, 32'hABAB_ABAB, 32'h0));
    tbl.push_back(mkv(32'h0000_0202, 32'h0,        1, 0, 3'b101, 7,  1, 0, 2, 32'hBEEF_0000,32'h0000_0200,4'b1111, 32'h0,        32'hBEEF_0000));
    tbl.push_back(mkv(32'h0000_002E, 32'h1234_CDEF,0, 1, 3'b001, 0,  0, 0, 0, 32'h0,        32'h0000_002C,4'b1100, 32'hCDEF_CDEF, 32'h0));
    tbl.push_back(mkv(32'h0000_0040, 32'hDEAD_BEEF,0, 1, 3'b010, 0,  0, 2, 0, 32'h0,        32'h0000_0040,4'b1111, 32'hDEAD_BEEF, 32'h0));
    tbl.push_back(mkv(32'h0000_0080, 32'h0,        1, 0, 3'b010, 9,  1, 0, 0, 32'h1122_3344,32'h0000_0080,4'b1111, 32'h0,        32'h1122_3344));
    tbl.push_back(mkv(32'h0000_0001, 32'h0000_005A,1, 1, 3'b000, 3,  0, 0, 1, 32'h0,        32'h0000_0000,4'b0010, 32'h5A5A_5A5A, 32'h0));
    tbl.push_back(mkv(32'h0000_0010, 32'h0,        1, 0, 3'b100, 31, 1, 1, 1, 32'h0000_00F7,32'h0000_0010,4'b1111, 32'h0,        32'h0000_00F7));

    rst_n = 1'b0; valid = 1'b0; ex_data = '0; store_data = '0; mem_read = 1'b0;
    mem_write = 1'b0; funct3 = '0; rd_addr = '0; reg_write = 1'b0;
    dready = 1'b0; drvalid = 1'b0; drdata_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.req",   32'(dreq),  32'd0);
    chk("rst.wb",    32'(wb_valid), 32'd0);
    chk("rst.mask",  32'(dmask), 32'd0);
    chk("rst.ex_out", ex_out, 32'd0);
    chk("rst.rd",    32'(o_rd), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < tbl.size(); i++) begin
      run_op(tbl[i], $sformatf("tbl%0d", i));
      idle_check($sformatf("tbl%0d", i));
    end

    // Back-to-back: LW then ADD accepted in the LW completion cycle
    run_op(tbl[5], "b2b.lw");
    run_op(mkv(32'h0000_00AD, 32'h0, 0, 0, 3'b000, 12, 1, 0, 0, 32'h0,
               32'h0, 4'h0, 32'h0, 32'h0), "b2b.add");
    idle_check("b2b");

    // Misaligned word load at 0x6
    v = model(mkv(32'h0000_0006, 32'h0, 1, 0, 3'b010, 4, 1, 0, 0, 32'hCAFE_F00D,
                  32'h0, 4'h0, 32'h0, 32'h0));
`ifdef MEM_MISALIGN_TRAP_EN
    chk("misal.model", 32'(v.e_misal), 32'd1);
`else
    chk("misal.addr_model", v.e_addr, 32'h0000_0004);
`endif
    run_op(v, "lw6");
    idle_check("lw6");

    // Reset while waiting in RESP, then a stray rvalid
    valid = 1'b1; ex_data = 32'h0000_0300; mem_read = 1'b1; mem_write = 1'b0;
    funct3 = 3'b010; rd_addr = 5'd6; reg_write = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0; dready = 1'b1;
    @(posedge clk); #1;
    dready = 1'b0;
    chk("rstmid.stall_resp", 32'(stall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid.stall", 32'(stall), 32'd0);
    chk("rstmid.req",   32'(dreq),  32'd0);
    chk("rstmid.addr",  daddr,      32'd0);
    chk("rstmid.wb",    32'(wb_valid), 32'd0);
    chk("rstmid.ex_out", ex_out,    32'd0);
    chk("rstmid.rdata", rdata_out,  32'd0);
    chk("rstmid.flags", {28'd0, o_mread, is_word, is_hb, is_uns}, 32'd0);
    chk("rstmid.rd_rw", {26'd0, o_rd, o_rw}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drvalid = 1'b1; drdata_in = 32'h5555_AAAA;
    @(posedge clk); #1;
    drvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rstmid.no_wb", 32'(wb_valid), 32'd0);
      chk("rstmid.idle",  32'(stall),    32'd0);
      @(posedge clk); #1;
    end

    // Random operations against the model
    for (int n = 0; n < 60; n++) begin
      int kind = $urandom_range(0, 3);
      vec_t r;
      r.ex = $urandom; r.sd = $urandom; r.rd = 5'($urandom); r.rw = 1'($urandom);
      r.rdy_dly = $urandom_range(0, 2); r.rv_dly = $urandom_range(0, 2);
      r.rdata = $urandom;
      r.mr = (kind == 1) || (kind == 3);
      r.mw = (kind == 2) || (kind == 3);
      if (kind == 1) r.f3 = ld_f3s[$urandom_range(0, 4)];
      else if (kind == 0) r.f3 = 3'($urandom);
      else r.f3 = 3'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) r.ex[1:0] = 2'b00;
      r = model(r);
      run_op(r, $sformatf("rnd%0d", n));
      if ($urandom_range(0, 1) == 1) idle_check($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
